// File: rtl/pwm_shift_pkg.sv
// Shared types and defaults for the PWM duty shift-register loader.
package pwm_shift_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_CLK_DIV = 4;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        GAP,
        LATCH
    } state_t;

endpackage

// File: rtl/shift_tick_gen.sv
// Phase timer for the loader: CLK_DIV down-counter, tick on terminal count.
module shift_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    output logic tick
);

    localparam int              CNT_W  = $clog2(CLK_DIV + 1);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    assign tick = (cnt_q == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (restart || tick) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/pwm_shift_loader.sv
// Serialises duty words MSB first into the PWM shift register, then pulses latch.
// Optional idle auto re-send of the last word: define SHIFT_LOADER_REFRESH_EN.
//
// state    | meaning
// IDLE     | waiting for a word (or refresh); in_ready high
// SHIFT_LO | sr_clk low, current MSB on sr_data
// SHIFT_HI | sr_clk high; shift and count bit on exit
// GAP      | sr_clk and sr_data low before the latch
// LATCH    | sr_latch high; done follows on exit
module pwm_shift_loader
    import pwm_shift_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int CLK_DIV        = DEF_CLK_DIV,
    parameter int REFRESH_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              sr_clk,
    output logic              sr_data,
    output logic              sr_latch,
    output logic              busy,
    output logic              done
);

    localparam int BIT_W = $clog2(DATA_W);

    if (DATA_W < 2 || CLK_DIV < 1 || REFRESH_CYCLES < 1) begin : g_param_check
        $error("pwm_shift_loader: DATA_W>=2, CLK_DIV>=1, REFRESH_CYCLES>=1 required");
    end

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q;
    logic [BIT_W-1:0]  bit_cnt_q;
    logic              tick;
    logic              accept;
    logic              start;
    logic [DATA_W-1:0] start_word;
    logic              last_bit;

    // in_ready is the registered handshake; it only rises once the FSM sits in IDLE
    assign accept   = (state_q == IDLE) && in_ready && in_valid;
    assign last_bit = (bit_cnt_q == BIT_W'(DATA_W - 1));

`ifdef SHIFT_LOADER_REFRESH_EN
    localparam int               IDLE_W      = $clog2(REFRESH_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_RELOAD = IDLE_W'(REFRESH_CYCLES - 1);

    logic [DATA_W-1:0] last_q;
    logic              last_vld_q;
    logic [IDLE_W-1:0] idle_cnt_q;
    logic              refresh;

    // a real word presented on the expiry cycle takes priority over the re-send
    assign refresh = (state_q == IDLE) && in_ready && last_vld_q &&
                     (idle_cnt_q == '0) && !in_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q     <= '0;
            last_vld_q <= 1'b0;
            idle_cnt_q <= IDLE_RELOAD;
        end else if (accept) begin
            last_q     <= in_data;
            last_vld_q <= 1'b1;
            idle_cnt_q <= IDLE_RELOAD;
        end else if (state_q != IDLE || !in_ready || refresh) begin
            idle_cnt_q <= IDLE_RELOAD;
        end else if (last_vld_q) begin
            idle_cnt_q <= idle_cnt_q - IDLE_W'(1);
        end
    end

    assign start      = accept || refresh;
    assign start_word = accept ? in_data : last_q;
`else
    assign start      = accept;
    assign start_word = in_data;
`endif

    shift_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .restart (state_q == IDLE),
        .tick    (tick)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (start) state_d = SHIFT_LO;
            SHIFT_LO: if (tick)  state_d = SHIFT_HI;
            SHIFT_HI: if (tick)  state_d = last_bit ? GAP : SHIFT_LO;
            GAP:      if (tick)  state_d = LATCH;
            LATCH:    if (tick)  state_d = IDLE;
            default:             state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (start) begin
                shift_q   <= start_word;
                bit_cnt_q <= '0;
            end else if (state_q == SHIFT_HI && tick) begin
                shift_q   <= {shift_q[DATA_W-2:0], 1'b0};
                bit_cnt_q <= last_bit ? '0 : bit_cnt_q + BIT_W'(1);
            end
        end
    end

    // pins are registered from the current state, one clock behind the FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            sr_clk   <= 1'b0;
            sr_data  <= 1'b0;
            sr_latch <= 1'b0;
            done     <= 1'b0;
        end else begin
            in_ready <= (state_q == IDLE) && !start;
            busy     <= !((state_q == IDLE) && !start);
            sr_clk   <= (state_q == SHIFT_HI);
            sr_data  <= ((state_q == SHIFT_LO) || (state_q == SHIFT_HI)) && shift_q[DATA_W-1];
            sr_latch <= (state_q == LATCH);
            done     <= sr_latch && (state_q != LATCH);
        end
    end

endmodule

// File: tb/tb_pwm_shift_loader.sv
// Directed bench for pwm_shift_loader: CLK_DIV=4 instance plus a CLK_DIV=1 instance.
module tb_pwm_shift_loader;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] in_data, f_in_data;
    logic       in_valid, f_in_valid;
    logic       in_ready, sr_clk, sr_data, sr_latch, busy, done;
    logic       f_in_ready, f_sr_clk, f_sr_data, f_sr_latch, f_busy, f_done;

    int n_checks = 0;
    int n_errors = 0;

    int cyc = 0;
    int acc_cyc, latch_rise, latch_fall, done_cyc, n_latch, n_rise, n_acc;
    logic [7:0] sr_model = '0, d_opwm = '0;
    logic clk_prev = 1'b0, latch_prev = 1'b0;
    bit   ready_at_done;

    int f_acc_cyc, f_latch_rise, f_done_cyc, f_n_latch, f_n_rise, f_rise1, f_rise2;
    logic [7:0] f_model = '0, f_dopwm = '0;
    logic f_clk_prev = 1'b0, f_latch_prev = 1'b0;

    always #5 clk = ~clk;

    pwm_shift_loader #(.DATA_W(8), .CLK_DIV(4), .REFRESH_CYCLES(1024)) u_dut (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .sr_clk(sr_clk), .sr_data(sr_data), .sr_latch(sr_latch),
        .busy(busy), .done(done)
    );

    pwm_shift_loader #(.DATA_W(8), .CLK_DIV(1), .REFRESH_CYCLES(16)) u_dut_fast (
        .clk(clk), .reset_n(reset_n), .in_data(f_in_data), .in_valid(f_in_valid),
        .in_ready(f_in_ready), .sr_clk(f_sr_clk), .sr_data(f_sr_data), .sr_latch(f_sr_latch),
        .busy(f_busy), .done(f_done)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one clock; sample #1 after the edge and update the downstream shift-register models
    task automatic step();
        bit acc, facc;
        acc  = in_valid && in_ready;
        facc = f_in_valid && f_in_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (acc) begin acc_cyc = cyc; n_acc++; end
        if (facc) f_acc_cyc = cyc;
        if (sr_clk && !clk_prev) begin sr_model = {sr_model[6:0], sr_data}; n_rise++; end
        if (sr_latch && !latch_prev) begin latch_rise = cyc; n_latch++; d_opwm = sr_model; end
        if (!sr_latch && latch_prev) latch_fall = cyc;
        if (done) begin done_cyc = cyc; ready_at_done = in_ready; end
        clk_prev   = sr_clk;
        latch_prev = sr_latch;
        if (f_sr_clk && !f_clk_prev) begin
            f_model = {f_model[6:0], f_sr_data};
            f_n_rise++;
            if (f_n_rise == 1) f_rise1 = cyc;
            if (f_n_rise == 2) f_rise2 = cyc;
        end
        if (f_sr_latch && !f_latch_prev) begin f_latch_rise = cyc; f_n_latch++; f_dopwm = f_model; end
        if (f_done) f_done_cyc = cyc;
        f_clk_prev   = f_sr_clk;
        f_latch_prev = f_sr_latch;
    endtask

    // present a word and hold it until accepted; caller drops in_valid
    task automatic send(input bit fast, input logic [7:0] w);
        bit ok;
        ok = 1'b0;
        if (fast) begin f_in_data = w; f_in_valid = 1'b1; end
        else begin in_data = w; in_valid = 1'b1; end
        for (int i = 0; i < 300 && !ok; i++) begin
            ok = fast ? f_in_ready : in_ready;
            step();
        end
        if (!ok) check_val("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_for_done(input bit fast);
        int n;
        n = 0;
        while (!(fast ? f_done : done) && n < 300) begin
            step();
            n++;
        end
        check_val("done_reached", 32'(fast ? f_done : done), 32'd1);
    endtask

    initial begin
        int d1;
        reset_n = 1'b0; in_data = '0; in_valid = 1'b0; f_in_data = '0; f_in_valid = 1'b0;
        acc_cyc = 0; latch_rise = 0; latch_fall = 0; done_cyc = 0;
        n_latch = 0; n_rise = 0; n_acc = 0; ready_at_done = 1'b0;
        f_acc_cyc = 0; f_latch_rise = 0; f_done_cyc = 0; f_n_latch = 0; f_n_rise = 0;
        f_rise1 = 0; f_rise2 = 0;

        repeat (2) @(posedge clk);
        #1;
        check_val("reset_outputs", {in_ready, busy, sr_clk, sr_data, sr_latch, done}, 32'd0);
        reset_n = 1'b1;
        step();
        check_val("ready_after_reset", {in_ready, busy}, 32'b10);

        // single word A5
        n_rise = 0; n_latch = 0;
        send(1'b0, 8'hA5);
        in_valid = 1'b0;
        wait_for_done(1'b0);
        check_val("a5_latch_rise", latch_rise - acc_cyc, 32'd69);
        check_val("a5_latch_fall", latch_fall - acc_cyc, 32'd73);
        check_val("a5_done_cycle", done_cyc - acc_cyc, 32'd73);
        check_val("a5_ready_at_done", 32'(ready_at_done), 32'd1);
        check_val("a5_rise_count", n_rise, 32'd8);
        check_val("a5_bits_at_rises", sr_model, 32'hA5);
        check_val("a5_duty", d_opwm, 32'hA5);
        check_val("a5_latch_count", n_latch, 32'd1);

        // back-to-back 00 then FF with in_valid held
        n_latch = 0;
        send(1'b0, 8'h00);
        in_data = 8'hFF;
        wait_for_done(1'b0);
        check_val("b2b_first_duty", d_opwm, 32'h00);
        d1 = done_cyc;
        step();
        check_val("b2b_second_accept", acc_cyc, 32'(d1 + 1));
        in_valid = 1'b0;
        wait_for_done(1'b0);
        check_val("b2b_second_duty", d_opwm, 32'hFF);
        check_val("b2b_latch_count", n_latch, 32'd2);

        // words offered while busy are ignored
        n_acc = 0;
        send(1'b0, 8'h96);
        in_valid = 1'b0;
        repeat (10) step();
        in_data = 8'h3C;
        for (int i = 0; i < 6; i++) begin
            in_valid = ~in_valid;
            step();
        end
        check_val("busy_ready_low", {in_ready, busy}, 32'b01);
        in_valid = 1'b0;
        wait_for_done(1'b0);
        check_val("busy_first_duty", d_opwm, 32'h96);
        check_val("busy_accept_count", n_acc, 32'd1);
        d1 = done_cyc;
        send(1'b0, 8'h3C);
        in_valid = 1'b0;
        check_val("busy_late_accept", acc_cyc, 32'(d1 + 1));
        wait_for_done(1'b0);
        check_val("busy_late_duty", d_opwm, 32'h3C);

        // reset in the middle of a C3 transfer
        n_latch = 0;
        send(1'b0, 8'hC3);
        in_valid = 1'b0;
        repeat (30) step();
        reset_n = 1'b0;
        #1;
        check_val("abort_outputs", {in_ready, busy, sr_clk, sr_data, sr_latch, done}, 32'd0);
        repeat (3) step();
        reset_n = 1'b1;
        repeat (80) step();
        check_val("abort_no_latch", n_latch, 32'd0);
        check_val("abort_duty_kept", d_opwm, 32'h3C);
        check_val("abort_ready", 32'(in_ready), 32'd1);
        n_rise = 0;
        send(1'b0, 8'h81);
        in_valid = 1'b0;
        wait_for_done(1'b0);
        check_val("after_abort_duty", d_opwm, 32'h81);
        check_val("after_abort_rises", n_rise, 32'd8);

        // CLK_DIV=1 instance, word 01
        f_n_rise = 0; f_n_latch = 0;
        send(1'b1, 8'h01);
        f_in_valid = 1'b0;
        wait_for_done(1'b1);
        check_val("fast_latch_rise", f_latch_rise - f_acc_cyc, 32'd18);
        check_val("fast_done_cycle", f_done_cyc - f_acc_cyc, 32'd19);
        check_val("fast_clk_period", f_rise2 - f_rise1, 32'd2);
        check_val("fast_rise_count", f_n_rise, 32'd8);
        check_val("fast_bits_at_rises", f_model, 32'h01);
        check_val("fast_duty", f_dopwm, 32'h01);

        send(1'b1, 8'h5A);
        f_in_valid = 1'b0;
        wait_for_done(1'b1);
        d1 = f_done_cyc;
        f_n_latch = 0;
`ifdef SHIFT_LOADER_REFRESH_EN
        for (int i = 0; i < 100 && f_n_latch == 0; i++) step();
        check_val("refresh_latch_rise", f_latch_rise, 32'(d1 + 34));
        check_val("refresh_duty", f_dopwm, 32'h5A);
        wait_for_done(1'b1);
        d1 = f_done_cyc;
        repeat (15) step();
        f_in_data = 8'h11;
        f_in_valid = 1'b1;
        step();
        f_in_valid = 1'b0;
        check_val("tie_accept_cycle", f_acc_cyc, 32'(d1 + 16));
        wait_for_done(1'b1);
        check_val("tie_duty", f_dopwm, 32'h11);
`else
        repeat (60) step();
        check_val("no_refresh_latch", f_n_latch, 32'd0);
        check_val("no_refresh_ready", 32'(f_in_ready), 32'd1);
        check_val("no_refresh_duty", f_dopwm, 32'h5A);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
